// File: rtl/ecc_load_ctrl_pkg.sv
// Shared types and SEC-DED (39,32) encoding helpers for the ECC load controller.
// Check bits [5:0] are Hamming checks over positions 1..38; bit 6 is overall parity.
package ecc_load_ctrl_pkg;

    localparam int DATA_W  = 32;
    localparam int PAR_W   = 7;
    localparam int HAM_POS = 38;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CHECK = 3'd2,
        SCRUB = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } state_t;

    // Data bits occupy the non-power-of-two positions 3,5,6,7,9,... in ascending order.
    function automatic logic [5:0] ham_checks(input logic [DATA_W-1:0] data);
        logic [5:0] chk;
        int         d;
        chk = '0;
        d   = 0;
        for (int p = 1; p <= HAM_POS; p++) begin
            if ((p & (p - 1)) != 0) begin
                for (int i = 0; i < 6; i++) begin
                    if (p[i]) chk[i] = chk[i] ^ data[d];
                end
                d++;
            end
        end
        return chk;
    endfunction

    function automatic logic [PAR_W-1:0] ecc_encode(input logic [DATA_W-1:0] data);
        logic [5:0] chk;
        chk = ham_checks(data);
        return {(^data) ^ (^chk), chk};
    endfunction

endpackage

// File: rtl/ecc_load_ctrl_correction_detection.sv
// SEC-DED checker: flags single/double errors and returns the corrected word
// together with freshly encoded check bits for scrubbing.
module correction_detection
    import ecc_load_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [PAR_W-1:0]  parity,
    output logic [DATA_W-1:0] corrected_data,
    output logic [PAR_W-1:0]  corrected_parity,
    output logic              single_err,
    output logic              double_err
);

    logic [5:0] syndrome;
    logic       overall;

    function automatic logic [DATA_W-1:0] fix_data(input logic [DATA_W-1:0] raw,
                                                   input logic [5:0] syn);
        logic [DATA_W-1:0] res;
        int                d;
        res = raw;
        d   = 0;
        for (int p = 1; p <= HAM_POS; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (syn == p[5:0]) res[d] = ~raw[d];
                d++;
            end
        end
        return res;
    endfunction

    always_comb begin
        syndrome       = ham_checks(data) ^ parity[5:0];
        overall        = ^{data, parity};
        single_err     = overall;
        double_err     = !overall && (syndrome != 6'd0);
        // A syndrome pointing at a check bit or at nothing leaves the data untouched.
        corrected_data = overall ? fix_data(data, syndrome) : data;
    end

    assign corrected_parity = ecc_encode(corrected_data);

endmodule

// File: rtl/ecc_load_ctrl.sv
// ECC-protected load controller: reads a cache word, checks/corrects it,
// scrubs single errors back to the cache and traps double errors.
module ecc_load_ctrl
    import ecc_load_ctrl_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld_req,
    input  logic [DATA_W-1:0]    ld_addr,
    input  logic                 special_load,
    output logic                 ld_ready,
    output logic                 ld_done,
    output logic [DATA_W-1:0]    ld_data,
    output logic                 cache_rd_en,
    output logic [DATA_W-1:0]    cache_addr,
    input  logic                 cache_rd_valid,
    input  logic [DATA_W-1:0]    data_Cache,
    input  logic [PAR_W-1:0]     parity_Cache,
    output logic                 cache_wr_en,
    output logic [DATA_W-1:0]    cache_wr_data,
    output logic [PAR_W-1:0]     cache_wr_parity,
    input  logic                 cache_wr_ack,
    output logic                 DED_exception,
    input  logic                 exc_ack,
    output logic [ERR_CNT_W-1:0] err_count
);

    state_t            state;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [PAR_W-1:0]  par_q;
    logic              special_q;
    logic [DATA_W-1:0] corr_data;
    logic [PAR_W-1:0]  corr_par;
    logic              single_err;
    logic              double_err;

    correction_detection u_correction_detection (
        .data             (data_q),
        .parity           (par_q),
        .corrected_data   (corr_data),
        .corrected_parity (corr_par),
        .single_err       (single_err),
        .double_err       (double_err)
    );

    assign cache_addr = addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            addr_q          <= '0;
            data_q          <= '0;
            par_q           <= '0;
            special_q       <= 1'b0;
            ld_ready        <= 1'b0;
            ld_done         <= 1'b0;
            ld_data         <= '0;
            cache_rd_en     <= 1'b0;
            cache_wr_en     <= 1'b0;
            cache_wr_data   <= '0;
            cache_wr_parity <= '0;
            DED_exception   <= 1'b0;
            err_count       <= '0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                IDLE: begin
                    // ld_ready comes out of reset low, so the first IDLE cycle only raises it.
                    if (!ld_ready) begin
                        ld_ready <= 1'b1;
                    end else if (ld_req) begin
                        addr_q      <= ld_addr;
                        special_q   <= special_load;
                        ld_ready    <= 1'b0;
                        cache_rd_en <= 1'b1;
                        state       <= READ;
                    end
                end
                READ: begin
                    if (cache_rd_valid) begin
                        data_q      <= data_Cache;
                        par_q       <= parity_Cache;
                        cache_rd_en <= 1'b0;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    if (!special_q && double_err) begin
                        DED_exception <= 1'b1;
                        state         <= FAULT;
                    end else if (!special_q && single_err) begin
                        cache_wr_en     <= 1'b1;
                        cache_wr_data   <= corr_data;
                        cache_wr_parity <= corr_par;
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        state           <= SCRUB;
                    end else begin
                        ld_done <= 1'b1;
                        ld_data <= special_q ? data_q : corr_data;
                        state   <= DONE;
                    end
                end
                SCRUB: begin
                    if (cache_wr_ack) begin
                        cache_wr_en <= 1'b0;
                        ld_done     <= 1'b1;
                        ld_data     <= corr_data;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    ld_ready <= 1'b1;
                    state    <= IDLE;
                end
                FAULT: begin
                    if (exc_ack) begin
                        DED_exception <= 1'b0;
                        ld_ready      <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_load_ctrl.sv
// Directed bench for ecc_load_ctrl: clean, single, double, special, saturation and reset-in-scrub loads.
module tb_ecc_load_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        special_load;
    logic        ld_ready;
    logic        ld_done;
    logic [31:0] ld_data;
    logic        cache_rd_en;
    logic [31:0] cache_addr;
    logic        cache_rd_valid;
    logic [31:0] data_cache;
    logic [6:0]  parity_cache;
    logic        cache_wr_en;
    logic [31:0] cache_wr_data;
    logic [6:0]  cache_wr_parity;
    logic        cache_wr_ack;
    logic        ded_exception;
    logic        exc_ack;
    logic [7:0]  err_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    ecc_load_ctrl #(.ERR_CNT_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .ld_req          (ld_req),
        .ld_addr         (ld_addr),
        .special_load    (special_load),
        .ld_ready        (ld_ready),
        .ld_done         (ld_done),
        .ld_data         (ld_data),
        .cache_rd_en     (cache_rd_en),
        .cache_addr      (cache_addr),
        .cache_rd_valid  (cache_rd_valid),
        .data_Cache      (data_cache),
        .parity_Cache    (parity_cache),
        .cache_wr_en     (cache_wr_en),
        .cache_wr_data   (cache_wr_data),
        .cache_wr_parity (cache_wr_parity),
        .cache_wr_ack    (cache_wr_ack),
        .DED_exception   (ded_exception),
        .exc_ack         (exc_ack),
        .err_count       (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference SEC-DED encoder: data bit k sits at the k-th non-power-of-two position.
    function automatic logic [6:0] enc(input logic [31:0] d);
        logic [6:0] p;
        int         pos;
        p   = '0;
        pos = 2;
        for (int k = 0; k < 32; k++) begin
            pos++;
            while ((pos & (pos - 1)) == 0) pos++;
            for (int b = 0; b < 6; b++) if ((pos >> b) & 1) p[b] = p[b] ^ d[k];
        end
        p[6] = ^{d, p[5:0]};
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        for (k = 0; k < 20 && !ld_ready; k++) @(negedge clk);
        if (!ld_ready) begin
            tests++;
            fails++;
            $display("FAIL wait_ready timeout observed=0 expected=1");
        end
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d, input logic [6:0] p,
                           input logic sp, output int done_off, output int wr_cnt,
                           output logic [31:0] wa, output logic [31:0] wd, output logic [6:0] wp,
                           output logic ded, output logic [31:0] rdata, output int overlap);
        int start;
        done_off = -1; wr_cnt = 0; wa = '0; wd = '0; wp = '0; ded = 1'b0; rdata = '0; overlap = 0;
        wait_ready();
        ld_req = 1'b1; ld_addr = a; special_load = sp; start = cyc;
        @(negedge clk);
        ld_req = 1'b0;
        cache_rd_valid = 1'b1; data_cache = d; parity_cache = p;
        @(negedge clk);
        cache_rd_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            cache_wr_ack = 1'b0;
            if (cache_rd_en && cache_wr_en) overlap++;
            if (cache_wr_en) begin
                wr_cnt++; wa = cache_addr; wd = cache_wr_data; wp = cache_wr_parity;
                cache_wr_ack = 1'b1;
            end
            if (ld_done) begin done_off = cyc - start; rdata = ld_data; break; end
            if (ded_exception) begin ded = 1'b1; break; end
            @(negedge clk);
        end
        cache_wr_ack = 1'b0;
    endtask

    localparam logic [31:0] WORD = 32'hDEADBEEF;

    initial begin
        int          done_off, wr_cnt, overlap;
        logic [31:0] wa, wd, rdata;
        logic [6:0]  wp, good_par;
        logic        ded;

        good_par = enc(WORD);
        reset = 1'b1; ld_req = 1'b0; ld_addr = '0; special_load = 1'b0;
        cache_rd_valid = 1'b0; data_cache = '0; parity_cache = '0;
        cache_wr_ack = 1'b0; exc_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ld_ready", {31'd0, ld_ready}, 32'd0);
        check("reset_err_count", {24'd0, err_count}, 32'd0);
        check("reset_cache_addr", cache_addr, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, ld_ready}, 32'd1);

        // Clean word
        do_load(32'h40, WORD, good_par, 1'b0, done_off, wr_cnt, wa, wd, wp, ded, rdata, overlap);
        check("clean_latency", done_off, 32'd3);
        check("clean_data", rdata, WORD);
        check("clean_no_write", wr_cnt, 32'd0);
        check("clean_err_count", {24'd0, err_count}, 32'd0);
        @(negedge clk);
        check("clean_ready_back", {31'd0, ld_ready}, 32'd1);

        // Single-bit flip on data bit 5
        do_load(32'h40, WORD ^ 32'h20, good_par, 1'b0, done_off, wr_cnt, wa, wd, wp, ded, rdata, overlap);
        check("single_latency", done_off, 32'd4);
        check("single_wr_count", wr_cnt, 32'd1);
        check("single_wr_addr", wa, 32'h40);
        check("single_wr_data", wd, WORD);
        check("single_wr_parity", {25'd0, wp}, {25'd0, good_par});
        check("single_ld_data", rdata, WORD);
        check("single_err_count", {24'd0, err_count}, 32'd1);
        check("single_no_overlap", overlap, 32'd0);

        // Double-bit flip on a normal load
        do_load(32'h44, WORD ^ 32'h3, good_par, 1'b0, done_off, wr_cnt, wa, wd, wp, ded, rdata, overlap);
        check("double_ded", {31'd0, ded}, 32'd1);
        check("double_no_done", done_off, -32'sd1);
        check("double_no_write", wr_cnt, 32'd0);
        repeat (3) @(negedge clk);
        check("double_ded_held", {31'd0, ded_exception}, 32'd1);
        check("double_ld_done_low", {31'd0, ld_done}, 32'd0);
        check("double_not_ready", {31'd0, ld_ready}, 32'd0);
        exc_ack = 1'b1;
        @(negedge clk);
        exc_ack = 1'b0;
        check("double_ded_cleared", {31'd0, ded_exception}, 32'd0);
        check("double_ready", {31'd0, ld_ready}, 32'd1);
        check("double_err_count", {24'd0, err_count}, 32'd1);

        // Special load with single flip returns the raw word
        do_load(32'h80, WORD ^ 32'h20, good_par, 1'b1, done_off, wr_cnt, wa, wd, wp, ded, rdata, overlap);
        check("special_latency", done_off, 32'd3);
        check("special_raw_data", rdata, 32'hDEADBECF);
        check("special_no_write", wr_cnt, 32'd0);
        check("special_err_count", {24'd0, err_count}, 32'd1);

        // Special load with double flip: no exception
        do_load(32'h84, WORD ^ 32'h3, good_par, 1'b1, done_off, wr_cnt, wa, wd, wp, ded, rdata, overlap);
        check("special_dbl_no_ded", {31'd0, ded}, 32'd0);
        check("special_dbl_raw", rdata, 32'hDEADBEEC);

        // Saturation: 300 more single-error loads
        for (int i = 0; i < 300; i++) begin
            do_load(i * 4, WORD ^ 32'h20, good_par, 1'b0, done_off, wr_cnt, wa, wd, wp, ded, rdata, overlap);
            if (i == 252) check("sat_count_254", {24'd0, err_count}, 32'd254);
        end
        check("sat_count_255", {24'd0, err_count}, 32'd255);
        check("sat_last_data", rdata, WORD);

        // Reset during SCRUB with ack withheld
        wait_ready();
        ld_req = 1'b1; ld_addr = 32'h40; special_load = 1'b0;
        @(negedge clk);
        ld_req = 1'b0;
        cache_rd_valid = 1'b1; data_cache = WORD ^ 32'h20; parity_cache = good_par;
        @(negedge clk);
        cache_rd_valid = 1'b0;
        for (int k = 0; k < 10 && !cache_wr_en; k++) @(negedge clk);
        check("rst_scrub_entered", {31'd0, cache_wr_en}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_wr_en_low", {31'd0, cache_wr_en}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        check("rst_wr_data", cache_wr_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_ready_low", {31'd0, ld_ready}, 32'd0);
        @(negedge clk);
        check("rst_ready_high", {31'd0, ld_ready}, 32'd1);
        check("rst_no_write", {31'd0, cache_wr_en}, 32'd0);

        do_load(32'h40, WORD, good_par, 1'b0, done_off, wr_cnt, wa, wd, wp, ded, rdata, overlap);
        check("post_rst_latency", done_off, 32'd3);
        check("post_rst_data", rdata, WORD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
